// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_stream_reader
// Description : Burst reader for a synchronous ROM with one-cycle read
//               latency. Walks base, base+1, ... (modulo 2**ADDRW) for len
//               words and presents the returned words as a valid/ready
//               stream with full backpressure, one word per cycle when the
//               sink never stalls.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               start_i, base_i,     - burst request (sampled only when idle)
//               len_i                  and its first address / word count
//               busy_o, done_o       - burst in progress / completion pulse
//               rom_addr_o           - registered ROM address
//               rom_data_i           - ROM dout for the address on rom_addr_o
//               m_data_o, m_valid_o, - output stream, m_last_o marks the
//               m_ready_i, m_last_o    final beat of a burst
// Revision    : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
    parameter int ADDRW = 8,
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [ADDRW-1:0] base_i,
    input  logic [ADDRW:0]   len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ADDRW-1:0] rom_addr_o,
    input  logic [DATAW-1:0] rom_data_i,
    output logic [DATAW-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o
);

    localparam logic [ADDRW:0] c_len_zero = '0;
    localparam logic [ADDRW:0] c_len_one  = {{ADDRW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW:0]   rem_q, rem_d;
    logic             infl_q, infl_d;
    logic             infl_last_q, infl_last_d;

    // Two-entry output buffer
    logic [DATAW-1:0] fifo_data_q [2];
    logic [1:0]       fifo_last_q;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;

    logic w_push;
    logic w_pop;
    logic w_issue_ok;
    logic w_done;

    assign w_push = infl_q;
    assign w_pop  = m_valid_o & m_ready_i;

    // Occupancy after this edge (buffer + word in flight, minus the beat
    // leaving) must leave room for one more word issued now.
    assign w_issue_ok = (({1'b0, count_q} + {2'b00, infl_q}) <
                         (3'd2 + {2'b00, w_pop}));

    // ------------------------------------------------------------------
    // Burst control: next-state and issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        w_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = base_i;
                    if (len_i == c_len_zero) begin
                        rem_d   = c_len_zero;
                        state_d = S_DRAIN;
                    end else begin
                        // The start edge itself issues the first read.
                        rem_d       = len_i - c_len_one;
                        infl_d      = 1'b1;
                        infl_last_d = (len_i == c_len_one);
                        state_d     = (len_i == c_len_one) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_issue_ok) begin
                    addr_d      = addr_q + 1'b1;
                    rem_d       = rem_q - c_len_one;
                    infl_d      = 1'b1;
                    infl_last_d = (rem_q == c_len_one);
                    if (rem_q == c_len_one) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!infl_q && (count_q == 2'd0)) begin
                    w_done  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: rom_data_i belongs to the read issued one edge ago
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= rom_data_i;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rom_addr_o = addr_q;
    assign m_valid_o  = (count_q != 2'd0);
    assign m_data_o   = fifo_data_q[rd_ptr_q];
    assign m_last_o   = fifo_last_q[rd_ptr_q] & m_valid_o;
    assign done_o     = w_done;
    assign busy_o     = (state_q != S_IDLE) & ~w_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_stream_reader
// Description : Self-checking bench for rom_stream_reader. A burst-level
//               model (queue of expected beats) is compared against the
//               stream every cycle; directed literal checks pin timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

    localparam int ADDRW = 8;
    localparam int DATAW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [ADDRW-1:0] base;
    logic [ADDRW:0]   len;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] rom_addr;
    logic [DATAW-1:0] rom_data;
    logic [DATAW-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .base_i     (base),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_last_o   (m_last)
    );

    // rom_addr is the ROM's address register, so dout is a lookup of it.
    logic [DATAW-1:0] rom [256];
    assign rom_data = rom[rom_addr];

    typedef struct packed {
        logic [DATAW-1:0] d;
        logic             l;
    } beat_t;

    beat_t       expq[$];
    beat_t       nb;
    bit          model_active;
    bit          exp_done;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    int          vectors;
    int          miscompares;
    int          rmode;         // 0: ready high, 1: random, 2: ready low
    int unsigned seed_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst-level model and per-cycle compare
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            model_active = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            exp_done = model_active && (expq.size() == 0);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(model_active && !exp_done));
            chk("no_spurious_beat", 32'(m_valid && (expq.size() == 0)), 32'd0);
            if (m_valid && (expq.size() != 0)) begin
                chk("beat_data", 32'(m_data), 32'(expq[0].d));
                chk("beat_last", 32'(m_last), 32'(expq[0].l));
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready && (expq.size() != 0)) begin
                void'(expq.pop_front());
            end
            if (exp_done) begin
                model_active = 1'b0;
            end else if (!model_active && start) begin
                model_active = 1'b1;
                for (int k = 0; k < int'(len); k++) begin
                    nb.d = rom[(int'(base) + k) % 256];
                    nb.l = (k == int'(len) - 1);
                    expq.push_back(nb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    // Returns in the first cycle after the start edge.
    task automatic do_start(input logic [ADDRW-1:0] b, input logic [ADDRW:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
        base  = 8'($urandom);
        len   = 9'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (model_active && (n < budget)) begin
            tick();
            n++;
        end
        chk("burst_completes", 32'(model_active), 32'd0);
    endtask

    initial begin
        seed_val    = $urandom(32'd20240611);
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b1;
        rmode   = 0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic burst, sink always ready
        do_start(8'h10, 9'd4);
        chk("t1_addr", 32'(rom_addr), 32'h10);
        chk("t1_c1_valid", 32'(m_valid), 32'd0);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_b0_valid", 32'(m_valid), 32'd1);
        chk("t1_b0_data", 32'(m_data), 32'hB5);
        chk("t1_b0_last", 32'(m_last), 32'd0);
        tick();
        chk("t1_b1_data", 32'(m_data), 32'hB4);
        tick();
        chk("t1_b2_data", 32'(m_data), 32'hB7);
        tick();
        chk("t1_b3_data", 32'(m_data), 32'hB6);
        chk("t1_b3_last", 32'(m_last), 32'd1);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_done_valid", 32'(m_valid), 32'd0);
        tick();
        chk("t1_done_clr", 32'(done), 32'd0);

        // Zero-length burst
        do_start(8'h33, 9'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_valid", 32'(m_valid), 32'd0);
        tick();
        chk("z_done_clr", 32'(done), 32'd0);

        // Start ignored mid-burst and in the done cycle
        do_start(8'h40, 9'd8);
        tick();
        tick();
        start = 1'b1;
        base  = 8'h99;
        len   = 9'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("ign_done", 32'(done), 32'd1);
        start = 1'b1;
        base  = 8'h77;
        len   = 9'd5;
        tick();
        chk("ign_idle_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        wait_idle(100);

        // Randomised backpressure
        rmode = 1;
        do_start(8'h10, 9'd64);
        wait_idle(2000);
        do_start(8'hFE, 9'd4);
        chk("model_q_size", 32'(expq.size()), 32'd4);
        chk("model_b0", 32'(expq[0].d), 32'h5B);
        chk("model_b1", 32'(expq[1].d), 32'h5A);
        chk("model_b2", 32'(expq[2].d), 32'hA5);
        chk("model_b3", 32'(expq[3].d), 32'hA4);
        chk("model_b3_last", 32'(expq[3].l), 32'd1);
        wait_idle(200);
        do_start(8'h80, 9'd256);
        wait_idle(5000);
        for (int r = 0; r < 12; r++) begin
            do_start(8'($urandom), 9'($urandom_range(0, 20)));
            wait_idle(500);
        end

        // Asynchronous reset with the buffer full
        rmode = 2;
        do_start(8'h20, 9'd10);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_data", 32'(m_data), 32'h85);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_data", 32'(m_data), 32'd0);
        chk("arst_last", 32'(m_last), 32'd0);
        chk("arst_addr", 32'(rom_addr), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rmode = 1;
        tick();
        do_start(8'h05, 9'd6);
        wait_idle(200);
        rmode = 0;
        do_start(8'hFF, 9'd3);
        wait_idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
